// File: rtl/date_edit_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// date_edit_ctrl : BCD date registers with push-button editing and RTC write-back.
// Optional DIAS_MES_EN: month/year-dependent day maximum. Revision 1.0
// ---------------------------------------------------------------------------
module date_edit_ctrl #(
  parameter logic [7:0] DD_RST = 8'h01,
  parameter logic [7:0] M_RST  = 8'h01,
  parameter logic [7:0] AN_RST = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_prog,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       rtc_valid,
  input  logic [7:0] rtc_dd,
  input  logic [7:0] rtc_mm,
  input  logic [7:0] rtc_an,
  input  logic       wr_ack,
  output logic [7:0] digit_DD,
  output logic [7:0] digit_M,
  output logic [7:0] digit_AN,
  output logic       Prog_on,
  output logic [3:0] Cursor,
  output logic       wr_req
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EDIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [3:0] CUR_DAY  = 4'd3;
  localparam logic [3:0] CUR_MON  = 4'd4;
  localparam logic [3:0] CUR_YEAR = 4'd5;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [3:0] cursor;
  logic [3:0] cursor_next;
  logic [7:0] dd_next;
  logic [7:0] m_next;
  logic [7:0] an_next;
  logic [7:0] day_lim;

  // Bit order {prog, up, down, right, left}; btn_s is the input register, btn_q its history.
  logic [4:0] btn_s;
  logic [4:0] btn_q;
  logic [4:0] btn_rise;
  logic       act_prog;
  logic       act_up;
  logic       act_down;
  logic       act_right;
  logic       act_left;

  assign btn_rise  = btn_s & ~btn_q;
  assign act_prog  = btn_rise[4];
  assign act_up    = btn_rise[3] & ~btn_rise[4];
  assign act_down  = btn_rise[2] & ~|btn_rise[4:3];
  assign act_right = btn_rise[1] & ~|btn_rise[4:2];
  assign act_left  = btn_rise[0] & ~|btn_rise[4:1];

  function automatic logic [7:0] sat_nib(input logic [7:0] v);
    sat_nib = {(v[7:4] > 4'd9) ? 4'd9 : v[7:4], (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) bcd_dec = {v[7:4] - 4'd1, 4'd9};
    else                bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Out-of-range values are pulled into [lo, hi] first, then stepped with wrap.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi, input logic up);
    logic [7:0] s;
    s = sat_nib(v);
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    if (up) bcd_step = (s == hi) ? lo : bcd_inc(s);
    else    bcd_step = (s == lo) ? hi : bcd_dec(s);
  endfunction

`ifdef DIAS_MES_EN
  function automatic logic is_leap(input logic [7:0] y);
    if (y[4]) is_leap = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
    else      is_leap = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
  endfunction

  always_comb begin
    day_lim = 8'h31;
    case (m_next)
      8'h02:                      day_lim = is_leap(an_next) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: day_lim = 8'h30;
      default:                    day_lim = 8'h31;
    endcase
  end
`else
  assign day_lim = 8'h31;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (act_prog) state_next = ST_EDIT;
      ST_EDIT:   if (act_prog) state_next = ST_COMMIT;
      ST_COMMIT: if (wr_ack)   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Prog_on = (state == ST_EDIT);
    Cursor  = (state == ST_EDIT) ? cursor : 4'd0;
    wr_req  = (state == ST_COMMIT);
  end

  always_comb begin
    m_next      = digit_M;
    an_next     = digit_AN;
    cursor_next = cursor;
    case (state)
      ST_IDLE: begin
        if (act_prog) cursor_next = CUR_DAY;
        if (rtc_valid) begin
          m_next  = rtc_mm;
          an_next = rtc_an;
        end
      end
      ST_EDIT: begin
        if (act_up || act_down) begin
          if (cursor == CUR_MON)  m_next  = bcd_step(digit_M, 8'h01, 8'h12, act_up);
          if (cursor == CUR_YEAR) an_next = bcd_step(digit_AN, 8'h00, 8'h99, act_up);
        end else if (act_right) begin
          cursor_next = (cursor >= CUR_YEAR) ? CUR_DAY : cursor + 4'd1;
        end else if (act_left) begin
          cursor_next = (cursor <= CUR_DAY) ? CUR_YEAR : cursor - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    dd_next = digit_DD;
    case (state)
      ST_IDLE: if (rtc_valid) dd_next = rtc_dd;
      ST_EDIT: begin
        if ((act_up || act_down) && (cursor == CUR_DAY))
          dd_next = bcd_step(digit_DD, 8'h01, day_lim, act_up);
`ifdef DIAS_MES_EN
        if ((act_up || act_down) && ((cursor == CUR_MON) || (cursor == CUR_YEAR))
            && (digit_DD > day_lim))
          dd_next = day_lim;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s    <= 5'd0;
      btn_q    <= 5'd0;
      cursor   <= CUR_DAY;
      digit_DD <= DD_RST;
      digit_M  <= M_RST;
      digit_AN <= AN_RST;
    end else begin
      btn_s    <= {btn_prog, btn_up, btn_down, btn_right, btn_left};
      btn_q    <= btn_s;
      cursor   <= cursor_next;
      digit_DD <= dd_next;
      digit_M  <= m_next;
      digit_AN <= an_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_date_edit_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_date_edit_ctrl : directed self-checking bench for date_edit_ctrl.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_date_edit_ctrl;

  localparam logic [4:0] B_PROG  = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00001;

`ifdef DIAS_MES_EN
  localparam logic [7:0] EXP_FEB23 = 8'h28;
  localparam logic [7:0] EXP_FEB24 = 8'h29;
`else
  localparam logic [7:0] EXP_FEB23 = 8'h31;
  localparam logic [7:0] EXP_FEB24 = 8'h31;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn;
  logic       rtc_valid;
  logic [7:0] rtc_dd, rtc_mm, rtc_an;
  logic       wr_ack;
  logic [7:0] digit_DD, digit_M, digit_AN;
  logic       Prog_on;
  logic [3:0] Cursor;
  logic       wr_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  date_edit_ctrl dut (
    .clk(clk), .reset(reset),
    .btn_prog(btn[4]), .btn_up(btn[3]), .btn_down(btn[2]),
    .btn_right(btn[1]), .btn_left(btn[0]),
    .rtc_valid(rtc_valid), .rtc_dd(rtc_dd), .rtc_mm(rtc_mm), .rtc_an(rtc_an),
    .wr_ack(wr_ack),
    .digit_DD(digit_DD), .digit_M(digit_M), .digit_AN(digit_AN),
    .Prog_on(Prog_on), .Cursor(Cursor), .wr_req(wr_req)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] m);
    btn = m;
    tick(2);
    btn = 5'd0;
    tick(2);
  endtask

  task automatic load(input logic [7:0] d, input logic [7:0] m, input logic [7:0] a);
    rtc_dd = d; rtc_mm = m; rtc_an = a; rtc_valid = 1'b1;
    tick(1);
    rtc_valid = 1'b0;
  endtask

  task automatic commit(input string tag);
    press(B_PROG);
    chk({tag, "_wr_req_hi"}, {7'd0, wr_req}, 8'd1);
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    chk({tag, "_wr_req_lo"}, {7'd0, wr_req}, 8'd0);
  endtask

  initial begin
    reset = 1'b1; btn = 5'd0; rtc_valid = 1'b0; wr_ack = 1'b0;
    rtc_dd = 8'h00; rtc_mm = 8'h00; rtc_an = 8'h00;
    tick(3);
    chk("rst_dd", digit_DD, 8'h01);
    chk("rst_m", digit_M, 8'h01);
    chk("rst_an", digit_AN, 8'h00);
    chk("rst_prog", {7'd0, Prog_on}, 8'd0);
    chk("rst_cursor", {4'd0, Cursor}, 8'd0);
    chk("rst_wr_req", {7'd0, wr_req}, 8'd0);
    reset = 1'b0;
    tick(1);

    load(8'h15, 8'h07, 8'h24);
    chk("load_dd", digit_DD, 8'h15);
    chk("load_m", digit_M, 8'h07);
    chk("load_an", digit_AN, 8'h24);

    // Action lands on the second edge after the button rises.
    btn = B_PROG;
    tick(1);
    chk("prog_lat1", {7'd0, Prog_on}, 8'd0);
    tick(1);
    chk("prog_lat2", {7'd0, Prog_on}, 8'd1);
    chk("edit_cursor", {4'd0, Cursor}, 8'd3);
    btn = 5'd0;
    tick(2);

    press(B_RIGHT); chk("right1", {4'd0, Cursor}, 8'd4);
    press(B_RIGHT); chk("right2", {4'd0, Cursor}, 8'd5);
    press(B_RIGHT); chk("right3", {4'd0, Cursor}, 8'd3);
    press(B_LEFT);  chk("left1", {4'd0, Cursor}, 8'd5);
    btn = B_RIGHT;
    tick(50);
    btn = 5'd0;
    tick(2);
    chk("hold_right", {4'd0, Cursor}, 8'd3);

    load(8'h88, 8'h88, 8'h88);
    chk("edit_rtc_ign", digit_DD, 8'h15);
    press(B_UP | B_RIGHT);
    chk("prio_dd", digit_DD, 8'h16);
    chk("prio_cursor", {4'd0, Cursor}, 8'd3);

    press(B_PROG);
    chk("commit_wr_req", {7'd0, wr_req}, 8'd1);
    chk("commit_prog", {7'd0, Prog_on}, 8'd0);
    chk("commit_cursor", {4'd0, Cursor}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      load(8'h11, 8'h11, 8'h11);
      tick(1);
    end
    press(B_UP);
    chk("frozen_dd", digit_DD, 8'h16);
    chk("frozen_m", digit_M, 8'h07);
    chk("frozen_an", digit_AN, 8'h24);
    chk("hold_wr_req", {7'd0, wr_req}, 8'd1);
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    chk("ack_wr_req", {7'd0, wr_req}, 8'd0);
    chk("ack_prog", {7'd0, Prog_on}, 8'd0);

    load(8'h31, 8'h12, 8'h00);
    chk("idle_reload", digit_DD, 8'h31);
    press(B_PROG);
    press(B_UP);    chk("day_up_wrap", digit_DD, 8'h01);
    press(B_DOWN);  chk("day_dn_wrap", digit_DD, 8'h31);
    press(B_RIGHT);
    press(B_UP);    chk("mon_up_wrap", digit_M, 8'h01);
    chk("mon_up_dd", digit_DD, 8'h31);
    press(B_DOWN);  chk("mon_dn_wrap", digit_M, 8'h12);
    press(B_RIGHT);
    press(B_DOWN);  chk("yr_dn_wrap", digit_AN, 8'h99);
    press(B_UP);    chk("yr_up_wrap", digit_AN, 8'h00);
    commit("c1");

    load(8'h09, 8'h07, 8'h24);
    press(B_PROG);
    press(B_UP);    chk("day_carry", digit_DD, 8'h10);
    press(B_DOWN);  chk("day_borrow", digit_DD, 8'h09);
    commit("c2");

    load(8'h45, 8'h00, 8'h24);
    press(B_PROG);
    press(B_UP);    chk("day_clamp_hi", digit_DD, 8'h01);
    press(B_RIGHT);
    press(B_DOWN);  chk("mon_clamp_lo", digit_M, 8'h12);
    commit("c3");

    load(8'h31, 8'h01, 8'h23);
    press(B_PROG);
    press(B_RIGHT);
    press(B_UP);
    chk("feb23_m", digit_M, 8'h02);
    chk("feb23_dd", digit_DD, EXP_FEB23);
    commit("c4");

    load(8'h31, 8'h01, 8'h24);
    press(B_PROG);
    press(B_RIGHT);
    press(B_UP);
    chk("feb24_m", digit_M, 8'h02);
    chk("feb24_dd", digit_DD, EXP_FEB24);
    commit("c5");

    load(8'h01, 8'h02, 8'h23);
    press(B_PROG);
    press(B_DOWN);  chk("feb23_dn_wrap", digit_DD, EXP_FEB23);
    commit("c6");

    press(B_PROG);
    press(B_PROG);
    chk("mid_commit_req", {7'd0, wr_req}, 8'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst_commit_req", {7'd0, wr_req}, 8'd0);
    chk("rst_commit_dd", digit_DD, 8'h01);
    wr_ack = 1'b1;
    tick(2);
    wr_ack = 1'b0;
    chk("no_retry_req", {7'd0, wr_req}, 8'd0);
    chk("no_retry_prog", {7'd0, Prog_on}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/date_edit_ctrl.md
Name: date_edit_ctrl

Overview:
- Produces the three BCD date registers (digit_DD, digit_M, digit_AN), plus Prog_on and Cursor, for the on-screen date text renderer.
- In normal mode it tracks the date read from the RTC controller.
- In programming mode the user edits day, month and year with push-buttons; the selected field is shown in red by the renderer.
- On exit from programming mode it hands the edited date back to the RTC controller with a req/ack write handshake.

Parameters:
DD_RST, 8'h01, BCD day value after reset
M_RST, 8'h01, BCD month value after reset
AN_RST, 8'h00, BCD year value after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_prog  in  1  level, already debounced; each rising edge toggles programming mode
btn_up  in  1  level, debounced; rising edge increments the selected field
btn_down  in  1  level, debounced; rising edge decrements the selected field
btn_right  in  1  level, debounced; rising edge moves the cursor right
btn_left  in  1  level, debounced; rising edge moves the cursor left
rtc_valid  in  1  one-cycle strobe: rtc_dd, rtc_mm and rtc_an hold a fresh read
rtc_dd  in  8  BCD day from the RTC
rtc_mm  in  8  BCD month from the RTC
rtc_an  in  8  BCD year from the RTC
wr_ack  in  1  RTC controller has accepted the write
digit_DD  out  8  BCD day [7:4] tens, [3:0] units
digit_M  out  8  BCD month
digit_AN  out  8  BCD year
Prog_on  out  1  high while in the EDIT state
Cursor  out  4  0 when not editing; 3 = day, 4 = month, 5 = year
wr_req  out  1  write request; the digit outputs are the write data

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE, digit_DD=DD_RST, digit_M=M_RST, digit_AN=AN_RST
  - Prog_on=0, Cursor=0, wr_req=0
  - Button history registers cleared.
- Reset mid-COMMIT drops wr_req on the same edge; no write is retried.
- Edge detection:
  - Each btn_* is registered once; edge = btn & ~btn_q.
  - An action takes effect at the second rising clk edge after the input goes high.
  - Holding a button produces exactly one action.
- Action priority when several edges occur in one cycle: prog > up > down > right > left. Only one action per cycle; the others are discarded.
- IDLE state:
  - rtc_valid=1 loads rtc_dd, rtc_mm and rtc_an into the digit registers on the next edge.
  - Edge on btn_prog -> EDIT with Cursor=3 and Prog_on=1.
  - Other buttons are ignored.
- EDIT state:
  - rtc_valid is ignored.
  - right: Cursor 3->4->5->3. left: Cursor 5->4->3->5.
  - up/down apply to the field selected by Cursor, in BCD arithmetic, wrapping at both ends:
    - Day range 01..31: up from 31 -> 01; down from 01 -> 31.
    - Month range 01..12: up from 12 -> 01; down from 01 -> 12.
    - Year range 00..99: up from 99 -> 00; down from 00 -> 99.
  - BCD carry and borrow are handled per nibble: units 9->0 carries into tens; 0->9 borrows from tens.
  - Digit outputs never carry a nibble above 9.
  - Edge on btn_prog -> COMMIT, with Prog_on=0, Cursor=0 and wr_req=1 on the same edge.
- COMMIT state:
  - wr_req stays high and the digit registers are frozen until wr_ack is sampled at 1.
  - On that edge wr_req=0 and state -> IDLE.
  - All buttons and rtc_valid are ignored.
  - wr_ack while not in COMMIT is ignored.
- Input values are loaded unchecked. Out-of-range RTC data is corrected only by the next up/down on that field:
  - The field is clamped to its maximum if above it, or to its minimum if below it.
  - The step (increment or decrement) is then applied.

Optional Feature:
DIAS_MES_EN
- Defined:
  - The day maximum depends on month and year: 28, 29, 30 or 31.
  - Leap year when the year is divisible by 4; 00 counts as leap.
  - Whenever month or year changes in EDIT, digit_DD is clamped to the new maximum on the same edge.
  - Day wrap uses that maximum; for example, down from 01 in month 02 of year 23 gives 28.
- Undefined: the day maximum is always 31 and no clamping is done.

Test Plan:
- Reset -> digits 01/01/00, Prog_on=0, Cursor=0, wr_req=0. Then rtc_valid with 8'h15, 8'h07, 8'h24 -> outputs 15/07/24 one edge later.
- btn_prog pulse -> Prog_on=1, Cursor=3. right x3 -> Cursor 4, 5, 3. left once -> 5. A held btn_right for 50 cycles -> one step only.
- EDIT, Cursor=3, day 8'h31, up -> 8'h01. down -> 8'h31. Day 8'h09, up -> 8'h10.
- Cursor=4, month 8'h12, up -> 8'h01. Cursor=5, year 8'h00, down -> 8'h99.
- btn_prog in EDIT -> wr_req=1, Prog_on=0. Hold wr_ack=0 for 10 cycles with rtc_valid pulses -> digits unchanged, wr_req stays 1. wr_ack=1 -> wr_req=0, state IDLE.
- With DIAS_MES_EN: day 31, month 01, year 23, month up -> month 02, day 28. Same with year 24 -> day 29. Without the macro -> day stays 31.
